// File: rtl/udp_echo_responder.sv
// rtl/udp_echo_responder.sv - echoes received UDP datagrams back to their sender
// through a 2-entry skid buffer, or discards them when echo is disabled.
module udp_echo_responder #(
  parameter int WIDTH = 512
) (
  input  logic               net_clk,
  input  logic               net_areset,
  input  logic               echo_en,
  input  logic               s_axis_udp_rx_metadata_valid,
  output logic               s_axis_udp_rx_metadata_ready,
  input  logic [175:0]       s_axis_udp_rx_metadata_data,
  input  logic               s_axis_udp_rx_data_valid,
  output logic               s_axis_udp_rx_data_ready,
  input  logic [WIDTH-1:0]   s_axis_udp_rx_data_data,
  input  logic [WIDTH/8-1:0] s_axis_udp_rx_data_keep,
  input  logic               s_axis_udp_rx_data_last,
  output logic               m_axis_udp_tx_metadata_valid,
  input  logic               m_axis_udp_tx_metadata_ready,
  output logic [175:0]       m_axis_udp_tx_metadata_data,
  output logic               m_axis_udp_tx_data_valid,
  input  logic               m_axis_udp_tx_data_ready,
  output logic [WIDTH-1:0]   m_axis_udp_tx_data_data,
  output logic [WIDTH/8-1:0] m_axis_udp_tx_data_keep,
  output logic               m_axis_udp_tx_data_last,
  output logic [31:0]        pkt_count,
  output logic [31:0]        drop_count,
  output logic [31:0]        len_err_count
);
  localparam int KW = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, META, DATA, DROP} state_t;
  state_t state, state_nx;

  logic [175:0]     meta_q;
  logic [15:0]      byte_cnt;
  logic [15:0]      beat_bytes;
  logic [16:0]      byte_sum;
  logic [15:0]      byte_nx;

  logic [WIDTH-1:0] sk_data [2];
  logic [KW-1:0]    sk_keep [2];
  logic             sk_last [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       sk_cnt;

  logic meta_hs, rx_hs, push, pop;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KW; i++)
      beat_bytes = beat_bytes + 16'(s_axis_udp_rx_data_keep[i]);
    byte_sum = {1'b0, byte_cnt} + {1'b0, beat_bytes};
    byte_nx  = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  end

  // Only rx metadata ready needs explicit reset gating; the rest derive from reset state.
  always_comb begin
    state_nx                     = state;
    s_axis_udp_rx_metadata_ready = 1'b0;
    s_axis_udp_rx_data_ready     = 1'b0;
    m_axis_udp_tx_metadata_valid = 1'b0;
    case (state)
      IDLE: begin
        s_axis_udp_rx_metadata_ready = ~net_areset;
        if (s_axis_udp_rx_metadata_valid && !net_areset)
          state_nx = echo_en ? META : DROP;
      end
      META: begin
        m_axis_udp_tx_metadata_valid = 1'b1;
        if (m_axis_udp_tx_metadata_ready)
          state_nx = DATA;
      end
      DATA: begin
        s_axis_udp_rx_data_ready = (sk_cnt != 2'd2);
        if (s_axis_udp_rx_data_valid && sk_cnt != 2'd2 && s_axis_udp_rx_data_last)
          state_nx = IDLE;
      end
      DROP: begin
        s_axis_udp_rx_data_ready = 1'b1;
        if (s_axis_udp_rx_data_valid && s_axis_udp_rx_data_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign meta_hs = s_axis_udp_rx_metadata_valid && s_axis_udp_rx_metadata_ready;
  assign rx_hs   = s_axis_udp_rx_data_valid && s_axis_udp_rx_data_ready;
  assign push    = (state == DATA) && rx_hs;
  assign pop     = m_axis_udp_tx_data_valid && m_axis_udp_tx_data_ready;

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      state         <= IDLE;
      meta_q        <= '0;
      byte_cnt      <= '0;
      pkt_count     <= '0;
      drop_count    <= '0;
      len_err_count <= '0;
    end else begin
      state <= state_nx;
      if (meta_hs) begin
        meta_q   <= s_axis_udp_rx_metadata_data;
        byte_cnt <= '0;
      end
      if (push) begin
        byte_cnt <= byte_nx;
        if (s_axis_udp_rx_data_last) begin
          pkt_count <= pkt_count + 32'd1;
          if (byte_nx != meta_q[175:160])
            len_err_count <= len_err_count + 32'd1;
        end
      end
      if (state == DROP && rx_hs && s_axis_udp_rx_data_last)
        drop_count <= drop_count + 32'd1;
    end
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      sk_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge net_clk) begin
    if (push) begin
      sk_data[wr_ptr] <= s_axis_udp_rx_data_data;
      sk_keep[wr_ptr] <= s_axis_udp_rx_data_keep;
      sk_last[wr_ptr] <= s_axis_udp_rx_data_last;
    end
  end

  assign m_axis_udp_tx_metadata_data = meta_q;
  assign m_axis_udp_tx_data_valid    = (sk_cnt != 2'd0);
  assign m_axis_udp_tx_data_data     = sk_data[rd_ptr];
  assign m_axis_udp_tx_data_keep     = sk_keep[rd_ptr];
  assign m_axis_udp_tx_data_last     = sk_last[rd_ptr];
endmodule

// File: tb/tb_udp_echo_responder.sv
// tb/tb_udp_echo_responder.sv - directed self-checking bench for udp_echo_responder.
module tb_udp_echo_responder;
  localparam int WIDTH = 512;
  localparam int KW = WIDTH / 8;

  logic             net_clk = 1'b0;
  logic             net_areset;
  logic             echo_en;
  logic             s_axis_udp_rx_metadata_valid;
  logic             s_axis_udp_rx_metadata_ready;
  logic [175:0]     s_axis_udp_rx_metadata_data;
  logic             s_axis_udp_rx_data_valid;
  logic             s_axis_udp_rx_data_ready;
  logic [WIDTH-1:0] s_axis_udp_rx_data_data;
  logic [KW-1:0]    s_axis_udp_rx_data_keep;
  logic             s_axis_udp_rx_data_last;
  logic             m_axis_udp_tx_metadata_valid;
  logic             m_axis_udp_tx_metadata_ready;
  logic [175:0]     m_axis_udp_tx_metadata_data;
  logic             m_axis_udp_tx_data_valid;
  logic             m_axis_udp_tx_data_ready;
  logic [WIDTH-1:0] m_axis_udp_tx_data_data;
  logic [KW-1:0]    m_axis_udp_tx_data_keep;
  logic             m_axis_udp_tx_data_last;
  logic [31:0]      pkt_count, drop_count, len_err_count;

  udp_echo_responder #(.WIDTH(WIDTH)) dut (
    .net_clk(net_clk), .net_areset(net_areset), .echo_en(echo_en),
    .s_axis_udp_rx_metadata_valid(s_axis_udp_rx_metadata_valid),
    .s_axis_udp_rx_metadata_ready(s_axis_udp_rx_metadata_ready),
    .s_axis_udp_rx_metadata_data(s_axis_udp_rx_metadata_data),
    .s_axis_udp_rx_data_valid(s_axis_udp_rx_data_valid),
    .s_axis_udp_rx_data_ready(s_axis_udp_rx_data_ready),
    .s_axis_udp_rx_data_data(s_axis_udp_rx_data_data),
    .s_axis_udp_rx_data_keep(s_axis_udp_rx_data_keep),
    .s_axis_udp_rx_data_last(s_axis_udp_rx_data_last),
    .m_axis_udp_tx_metadata_valid(m_axis_udp_tx_metadata_valid),
    .m_axis_udp_tx_metadata_ready(m_axis_udp_tx_metadata_ready),
    .m_axis_udp_tx_metadata_data(m_axis_udp_tx_metadata_data),
    .m_axis_udp_tx_data_valid(m_axis_udp_tx_data_valid),
    .m_axis_udp_tx_data_ready(m_axis_udp_tx_data_ready),
    .m_axis_udp_tx_data_data(m_axis_udp_tx_data_data),
    .m_axis_udp_tx_data_keep(m_axis_udp_tx_data_keep),
    .m_axis_udp_tx_data_last(m_axis_udp_tx_data_last),
    .pkt_count(pkt_count), .drop_count(drop_count), .len_err_count(len_err_count)
  );

  always #5 net_clk = ~net_clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic tog = 1'b0;

  always @(posedge net_clk) cyc <= cyc + 1;

  // Transfer log, sampled mid-cycle so it never races the DUT or the driver.
  logic [WIDTH-1:0] txd_q[$];
  logic [KW-1:0]    txk_q[$];
  logic             txl_q[$];
  int               txc_q[$];
  logic [175:0]     txm_q[$];
  int               txv_cnt = 0;

  always @(negedge net_clk) begin
    #1;
    if (m_axis_udp_tx_data_valid && m_axis_udp_tx_data_ready) begin
      txd_q.push_back(m_axis_udp_tx_data_data);
      txk_q.push_back(m_axis_udp_tx_data_keep);
      txl_q.push_back(m_axis_udp_tx_data_last);
      txc_q.push_back(cyc);
    end
    if (m_axis_udp_tx_metadata_valid && m_axis_udp_tx_metadata_ready)
      txm_q.push_back(m_axis_udp_tx_metadata_data);
    if (m_axis_udp_tx_data_valid || m_axis_udp_tx_metadata_valid)
      txv_cnt++;
  end

  function automatic logic [WIDTH-1:0] mk(input int v);
    logic [31:0] w;
    w = v;
    return {16{w}};
  endfunction

  function automatic logic [175:0] mkmeta(input logic [15:0] len, input logic [31:0] ip);
    return {len, 16'd7, 16'd4000, 96'h0, ip};
  endfunction

  task automatic step();
    @(posedge net_clk);
    #1;
    if (tog) m_axis_udp_tx_data_ready = ~m_axis_udp_tx_data_ready;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_meta(input logic [175:0] m, output int acc_cyc);
    int n;
    n = 0;
    s_axis_udp_rx_metadata_valid = 1'b1;
    s_axis_udp_rx_metadata_data  = m;
    @(negedge net_clk);
    while (!s_axis_udp_rx_metadata_ready && n < 200) begin
      step();
      @(negedge net_clk);
      n++;
    end
    compared++;
    if (s_axis_udp_rx_metadata_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL meta_accept: ready=%0b after %0d cycles, required 1", s_axis_udp_rx_metadata_ready, n);
    end
    acc_cyc = cyc;
    step();
    s_axis_udp_rx_metadata_valid = 1'b0;
  endtask

  task automatic send_beats(input int nb, input int nsend, input logic [KW-1:0] lastkeep,
                            input int base, input bit chk_occ, input int txbase,
                            output int first_cyc, output int last_cyc, output int ncyc);
    int i, n, occ;
    i = 0; n = 0; first_cyc = -1; last_cyc = -1;
    while (i < nsend && n < 500) begin
      s_axis_udp_rx_data_valid = 1'b1;
      s_axis_udp_rx_data_data  = mk(base + i);
      s_axis_udp_rx_data_keep  = (i == nb - 1) ? lastkeep : {KW{1'b1}};
      s_axis_udp_rx_data_last  = (i == nb - 1);
      @(negedge net_clk);
      if (chk_occ && i > 0) begin
        occ = i - (txd_q.size() - txbase);
        compared++;
        if (s_axis_udp_rx_data_ready !== (occ < 2)) begin
          mismatched++;
          $display("FAIL rx_ready_vs_full: ready=%0b, required %0b (occupancy %0d)", s_axis_udp_rx_data_ready, occ < 2, occ);
        end
      end
      if (s_axis_udp_rx_data_ready) begin
        if (i == 0) first_cyc = cyc;
        last_cyc = cyc;
        i++;
      end
      step();
      n++;
    end
    s_axis_udp_rx_data_valid = 1'b0;
    s_axis_udp_rx_data_last  = 1'b0;
    ncyc = n;
    compared++;
    if (i != nsend) begin
      mismatched++;
      $display("FAIL beats_accepted: got %0d, required %0d", i, nsend);
    end
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    while (txd_q.size() < target && n < 300) begin step(); n++; end
    compared++;
    if (txd_q.size() != target) begin
      mismatched++;
      $display("FAIL drain: tx beats %0d, required %0d", txd_q.size(), target);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    net_areset = 1'b1;
    echo_en = 1'b0;
    s_axis_udp_rx_metadata_valid = 1'b1;
    s_axis_udp_rx_metadata_data = '0;
    s_axis_udp_rx_data_valid = 1'b0;
    s_axis_udp_rx_data_data = '0;
    s_axis_udp_rx_data_keep = '0;
    s_axis_udp_rx_data_last = 1'b0;
    m_axis_udp_tx_metadata_ready = 1'b1;
    m_axis_udp_tx_data_ready = 1'b1;
    repeat (3) @(posedge net_clk);
    @(negedge net_clk);
    chk32("reset_meta_ready", {31'b0, s_axis_udp_rx_metadata_ready}, 32'd0);
    chk32("reset_rx_ready", {31'b0, s_axis_udp_rx_data_ready}, 32'd0);
    chk32("reset_tx_valids", {30'b0, m_axis_udp_tx_metadata_valid, m_axis_udp_tx_data_valid}, 32'd0);
    chk32("reset_pkt_count", pkt_count, 32'd0);
    chk32("reset_drop_count", drop_count, 32'd0);
    chk32("reset_len_err_count", len_err_count, 32'd0);
    s_axis_udp_rx_metadata_valid = 1'b0;
    @(posedge net_clk);
    #1 net_areset = 1'b0;
    @(negedge net_clk);
    chk32("release_meta_ready", {31'b0, s_axis_udp_rx_metadata_ready}, 32'd1);
    step();
  endtask

  task automatic test_drop();
    int acc, f, l, n, v0, d0, m0;
    echo_en = 1'b0;
    v0 = txv_cnt; d0 = txd_q.size(); m0 = txm_q.size();
    send_meta(mkmeta(16'h00C0, 32'h0A00_0002), acc);
    send_beats(3, 3, {KW{1'b1}}, 100, 1'b0, 0, f, l, n);
    idle(3);
    chk32("drop_cycles", n, 32'd3);
    chk32("drop_span", l - f, 32'd2);
    chk32("drop_tx_valid_cycles", txv_cnt - v0, 32'd0);
    chk32("drop_tx_beats", txd_q.size() - d0 + txm_q.size() - m0, 32'd0);
    chk32("drop_count", drop_count, 32'd1);
    chk32("drop_pkt_count", pkt_count, 32'd0);
  endtask

  task automatic test_echo();
    int acc, f, l, n, b0, m0;
    logic [175:0] m;
    echo_en = 1'b1;
    m = mkmeta(16'h0040, 32'hC0A8_0001);
    b0 = txd_q.size(); m0 = txm_q.size();
    send_meta(m, acc);
    echo_en = 1'b0;
    send_beats(1, 1, {KW{1'b1}}, 200, 1'b0, 0, f, l, n);
    idle(3);
    echo_en = 1'b1;
    chk32("echo_meta_cnt", txm_q.size() - m0, 32'd1);
    compared++;
    if (txm_q[m0] !== m) begin
      mismatched++;
      $display("FAIL echo_meta: got %0h, required %0h", txm_q[m0], m);
    end
    chk32("echo_beat_cnt", txd_q.size() - b0, 32'd1);
    compared++;
    if (txd_q[b0] !== mk(200) || txk_q[b0] !== {KW{1'b1}} || txl_q[b0] !== 1'b1) begin
      mismatched++;
      $display("FAIL echo_beat: keep %0h last %0b, required all-ones/1 with data %0h", txk_q[b0], txl_q[b0], mk(200));
    end
    chk32("echo_latency", txc_q[b0], f + 1);
    chk32("echo_pkt_count", pkt_count, 32'd1);
    chk32("echo_len_err_count", len_err_count, 32'd0);
  endtask

  task automatic test_len_err();
    int acc, f, l, n, b0;
    b0 = txd_q.size();
    send_meta(mkmeta(16'd100, 32'hC0A8_0003), acc);
    send_beats(3, 3, 64'h0000_0000_000F_FFFF, 300, 1'b0, 0, f, l, n);
    idle(4);
    chk32("len_err_beats", txd_q.size() - b0, 32'd3);
    chk32("len_err_last_keep", txk_q[b0 + 2][31:0], 32'h000F_FFFF);
    chk32("len_err_pkt_count", pkt_count, 32'd2);
    chk32("len_err_count", len_err_count, 32'd1);
  endtask

  task automatic test_backpressure();
    int acc, f, l, n, b0, m0;
    logic [175:0] m;
    m = mkmeta(16'h0200, 32'hC0A8_0004);
    m0 = txm_q.size();
    m_axis_udp_tx_metadata_ready = 1'b0;
    send_meta(m, acc);
    for (int k = 0; k < 5; k++) begin
      @(negedge net_clk);
      compared++;
      if (m_axis_udp_tx_metadata_valid !== 1'b1 || m_axis_udp_tx_metadata_data !== m) begin
        mismatched++;
        $display("FAIL meta_hold: valid %0b data %0h, required 1 / %0h", m_axis_udp_tx_metadata_valid, m_axis_udp_tx_metadata_data, m);
      end
      step();
    end
    m_axis_udp_tx_metadata_ready = 1'b1;
    tog = 1'b1;
    b0 = txd_q.size();
    send_beats(8, 8, {KW{1'b1}}, 400, 1'b1, b0, f, l, n);
    drain(b0 + 8);
    tog = 1'b0;
    m_axis_udp_tx_data_ready = 1'b1;
    idle(2);
    chk32("bp_meta_cnt", txm_q.size() - m0, 32'd1);
    for (int j = 0; j < 8; j++) begin
      compared++;
      if (txd_q[b0 + j] !== mk(400 + j) || txl_q[b0 + j] !== (j == 7)) begin
        mismatched++;
        $display("FAIL bp_order[%0d]: data %0h last %0b, required %0h / %0b", j, txd_q[b0 + j][31:0], txl_q[b0 + j], 400 + j, j == 7);
      end
    end
    chk32("bp_pkt_count", pkt_count, 32'd3);
  endtask

  task automatic test_back_to_back();
    int acc, f, l, n, b0, m0;
    logic [175:0] m1, m2;
    m1 = mkmeta(16'h0080, 32'hC0A8_0005);
    m2 = mkmeta(16'h0040, 32'hC0A8_0006);
    b0 = txd_q.size(); m0 = txm_q.size();
    send_meta(m1, acc);
    s_axis_udp_rx_metadata_valid = 1'b1;
    s_axis_udp_rx_metadata_data  = m2;
    send_beats(2, 2, {KW{1'b1}}, 500, 1'b0, 0, f, l, n);
    send_meta(m2, acc);
    chk32("b2b_meta_accept_cycle", acc, l + 1);
    send_beats(1, 1, {KW{1'b1}}, 600, 1'b0, 0, f, l, n);
    idle(4);
    chk32("b2b_pkt_count", pkt_count, 32'd5);
    chk32("b2b_beats", txd_q.size() - b0, 32'd3);
    chk32("b2b_order", {txd_q[b0][15:0], txd_q[b0 + 1][15:0]}, {16'd500, 16'd501});
    chk32("b2b_order2", txd_q[b0 + 2][31:0], 32'd600);
    compared++;
    if (txm_q[m0] !== m1 || txm_q[m0 + 1] !== m2) begin
      mismatched++;
      $display("FAIL b2b_meta: got %0h %0h, required %0h %0h", txm_q[m0], txm_q[m0 + 1], m1, m2);
    end
  endtask

  task automatic test_reset_mid();
    int acc, f, l, n, b0, m0;
    logic [175:0] m;
    send_meta(mkmeta(16'h0100, 32'hC0A8_0007), acc);
    send_beats(4, 2, {KW{1'b1}}, 700, 1'b0, 0, f, l, n);
    s_axis_udp_rx_data_valid = 1'b1;
    net_areset = 1'b1;
    #1;
    chk32("rst_mid_readies", {30'b0, s_axis_udp_rx_metadata_ready, s_axis_udp_rx_data_ready}, 32'd0);
    chk32("rst_mid_valids", {30'b0, m_axis_udp_tx_metadata_valid, m_axis_udp_tx_data_valid}, 32'd0);
    chk32("rst_mid_pkt_count", pkt_count, 32'd0);
    chk32("rst_mid_len_err_count", len_err_count, 32'd0);
    chk32("rst_mid_drop_count", drop_count, 32'd0);
    s_axis_udp_rx_data_valid = 1'b0;
    idle(2);
    net_areset = 1'b0;
    step();
    m = mkmeta(16'h0040, 32'hC0A8_0008);
    b0 = txd_q.size(); m0 = txm_q.size();
    send_meta(m, acc);
    send_beats(1, 1, {KW{1'b1}}, 800, 1'b0, 0, f, l, n);
    idle(3);
    chk32("rst_after_pkt_count", pkt_count, 32'd1);
    chk32("rst_after_len_err", len_err_count, 32'd0);
    chk32("rst_after_beats", txd_q.size() - b0, 32'd1);
    chk32("rst_after_data", txd_q[b0][31:0], 32'd800);
    compared++;
    if (txm_q[m0] !== m) begin
      mismatched++;
      $display("FAIL rst_after_meta: got %0h, required %0h", txm_q[m0], m);
    end
  endtask

  initial begin
    test_reset();
    test_drop();
    test_echo();
    test_len_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/udp_echo_responder.md
UDP_ECHO_RESPONDER -- requirements
Module: udp_echo_responder

Interface
REQ-001 Parameter: WIDTH, default 512, data-bus width in bits of both payload streams; keep width is WIDTH/8.
REQ-002 Ports (one clock; reset is asynchronous and active-high), listed as name  direction  width  meaning:
- net_clk  in  1  single clock for the whole block.
- net_areset  in  1  asynchronous, active-high reset.
- echo_en  in  1  echo enable; sampled only at metadata acceptance.
- s_axis_udp_rx_metadata_{valid,ready,data}  in/out/in  1/1/176  received-datagram metadata from the UDP stack.
- s_axis_udp_rx_data_{valid,ready,data,keep,last}  in/out/in/in/in  1/1/WIDTH/WIDTH/8/1  received payload.
- m_axis_udp_tx_metadata_{valid,ready,data}  out/in/out  1/1/176  transmit metadata to the UDP stack.
- m_axis_udp_tx_data_{valid,ready,data,keep,last}  out/in/out/out/out  1/1/WIDTH/WIDTH/8/1  transmit payload.
- pkt_count  out  32  datagrams echoed.
- drop_count  out  32  datagrams discarded.
- len_err_count  out  32  echoed datagrams whose counted payload bytes differ from the metadata length.
REQ-003 Metadata layout: [127:0] remote IP, IPv4 in [31:0]; [143:128] remote port; [159:144] local port; [175:160] payload length in bytes.

Function
REQ-004 FSM states: IDLE, META, DATA, DROP.
REQ-005 IDLE: s_axis_udp_rx_metadata_ready=1; all other ready and valid outputs are 0.
REQ-006 IDLE, on metadata handshake: latch the 176-bit word; next state is META if echo_en=1, else DROP.
REQ-007 META: m_axis_udp_tx_metadata_valid=1 with data equal to the latched word, unmodified; the stack's TX convention makes the echo reply an identity mapping.
REQ-008 META: valid holds with stable data until ready; on handshake, next state is DATA.
REQ-009 META: rx data ready=0 and rx metadata ready=0.
REQ-010 DATA: each rx beat is written into a 2-entry skid buffer; s_axis_udp_rx_data_ready = NOT skid-full.
REQ-011 Skid buffer: tx stream presents the head entry; data, keep and last are carried unchanged.
REQ-012 Skid buffer: latency from rx handshake to tx valid is exactly 1 cycle; sustained throughput is 1 beat/cycle when m_axis_udp_tx_data_ready=1.
REQ-013 Skid buffer: a simultaneous push and pop keeps occupancy unchanged.
REQ-014 DATA: a 16-bit byte counter adds popcount(keep) per accepted beat, saturating at 0xFFFF; it clears on each metadata acceptance.
REQ-015 DATA, on accepting the beat with last=1: next state is IDLE and pkt_count increments.
REQ-016 DATA, same event: len_err_count increments if the final byte count (including that beat) differs from latched [175:160].
REQ-017 The skid buffer may still be draining while in IDLE; a new metadata word may be accepted then, and ordering is preserved.
REQ-018 DROP: s_axis_udp_rx_data_ready=1 and beats are discarded; no tx metadata or data is produced.
REQ-019 DROP, on accepting last=1: next state is IDLE and drop_count increments.
REQ-020 Single-beat datagram (first beat has last=1) is legal in both DATA and DROP.
REQ-021 A change of echo_en mid-datagram has no effect on that datagram.
REQ-022 All counters wrap modulo 2^32; no counter increments twice in one cycle.
REQ-023 No combinational path exists from any m_*_ready to any s_*_ready, or from any s_*_valid to any m_*_valid.

Reset
REQ-024 While net_areset=1: FSM is IDLE, skid buffer is empty, and the byte counter and all three output counters are 0.
REQ-025 While net_areset=1: every valid and ready output is 0, including s_axis_udp_rx_metadata_ready.
REQ-026 Reset assertion takes effect immediately, asynchronously; deassertion is released on the net_clk edge; rx metadata ready is 1 on the first cycle after release.
REQ-027 Reset asserted mid-datagram discards the in-flight datagram and the skid contents; no counter increments for that datagram.

Verification
REQ-028 Echo: echo_en=1, meta length=0x0040, one 64-byte beat with all keep set and last=1, tx always ready.
- Tx metadata equals rx metadata.
- Tx beat appears 1 cycle after the rx handshake with identical data/keep/last.
- pkt_count=1, len_err_count=0.
REQ-029 Drop: echo_en=0, 3-beat datagram.
- Rx data is accepted at 1 beat/cycle.
- No tx valid is asserted.
- drop_count=1, pkt_count=0.
REQ-030 Length error: meta length=100, two beats of keep all-ones plus keep=0x000F_FFFF on the last beat.
- Counted bytes are 148; datagram is still echoed.
- len_err_count=1.
REQ-031 Backpressure: 8-beat datagram with m_axis_udp_tx_data_ready toggling every cycle.
- No beat is lost or duplicated and order is kept.
- Rx ready deasserts only when the skid buffer is full.
- Tx metadata held for 5 cycles while not ready keeps its data stable.
REQ-032 Back-to-back: two datagrams with metadata presented continuously.
- The second metadata word is accepted in the cycle after the first datagram's last beat is accepted.
- pkt_count=2.
REQ-033 Reset mid-DATA: assert net_areset after 2 of 4 beats.
- All outputs return to reset values immediately.
- After release the next datagram echoes correctly and pkt_count=1.
